// File: rtl/dropout_layer_stream.sv
// dropout_layer_stream: streaming inverted-dropout stage.
// LFSR Bernoulli mask, fixed-point keep scaling, per-vector drop stats.
module dropout_layer_stream #(
   parameter int unsigned DATA_W      = 24,
   parameter int unsigned VEC_LEN     = 128,
   parameter int unsigned DROP_THRESH = 64,
   parameter int unsigned SCALE       = 21845,
   parameter int unsigned SCALE_W     = 16,
   parameter int unsigned SCALE_FRAC  = 14,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         train_mode,
   input  logic                         seed_load,
   input  logic [DATA_W-1:0]            in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_last,
   output logic [$clog2(VEC_LEN+1)-1:0] drop_count,
   output logic                         count_valid
);

   localparam int unsigned CW  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam int unsigned DCW = $clog2(VEC_LEN + 1);
   localparam int unsigned PW  = DATA_W + SCALE_W + 1;

   localparam logic [CW-1:0]      IDX_LAST = CW'(VEC_LEN - 1);
   localparam logic [8:0]         THR      = 9'(DROP_THRESH);
   localparam logic [SCALE_W-1:0] SCALE_V  = SCALE_W'(SCALE);
   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [15:0] SEED0 =
      (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

   localparam logic signed [PW-1:0] MAXV =
      {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [PW-1:0] MINV =
      {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   logic [CW-1:0]         idx;
   logic                  mode_q;
   logic [15:0]           lfsr;
   logic [15:0]           lfsr_nx;
   logic [DCW-1:0]        acc;
   logic                  accept;
   logic                  use_train;
   logic                  drop;
   logic                  last_el;
   logic signed [PW-1:0]  a_ext;
   logic signed [PW-1:0]  s_ext;
   logic signed [PW-1:0]  prod;
   logic signed [PW-1:0]  shifted;
   logic [DATA_W-1:0]     scaled;
   logic [DATA_W-1:0]     result;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign last_el  = (idx == IDX_LAST);

   // Mask decision, scaling with floor shift and saturation, result mux
   always_comb begin
      use_train = (idx == '0) ? train_mode : mode_q;
      drop      = use_train && ({1'b0, lfsr[7:0]} < THR);
      lfsr_nx   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      a_ext     = {{(PW-DATA_W){in_data[DATA_W-1]}}, in_data};
      s_ext     = {{(PW-SCALE_W){1'b0}}, SCALE_V};
      prod      = a_ext * s_ext;
      shifted   = prod >>> SCALE_FRAC;
      scaled    = shifted[DATA_W-1:0];
      if (shifted > MAXV) begin
         scaled = MAXV[DATA_W-1:0];
      end else if (shifted < MINV) begin
         scaled = MINV[DATA_W-1:0];
      end
      result = in_data;
      if (use_train) begin
         result = drop ? '0 : scaled;
      end
   end

   // Single output register: load on accept, empty when taken downstream
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (accept) begin
         out_data  <= result;
         out_valid <= 1'b1;
         out_last  <= last_el;
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

   // Element index and per-vector mode, latched on element 0
   always_ff @(posedge clk) begin
      if (rst) begin
         idx    <= '0;
         mode_q <= 1'b0;
      end else if (accept) begin
         idx <= last_el ? '0 : idx + CW'(1);
         if (idx == '0) begin
            mode_q <= train_mode;
         end
      end
   end

   // Mask LFSR: reload wins over advance; frozen outside train mode
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= SEED0;
      end else if (seed_load) begin
         lfsr <= SEED0;
      end else if (accept && use_train) begin
         lfsr <= lfsr_nx;
      end
   end

   // Drop accumulator, published with a pulse at each vector end
   always_ff @(posedge clk) begin
      if (rst) begin
         acc         <= '0;
         drop_count  <= '0;
         count_valid <= 1'b0;
      end else begin
         count_valid <= accept && last_el;
         if (accept) begin
            if (last_el) begin
               drop_count <= acc + DCW'(drop);
               acc        <= '0;
            end else begin
               acc <= acc + DCW'(drop);
            end
         end
      end
   end

endmodule
